muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit with its own sequencer; replaces the single-cycle 64-bit multiplier path in the EX stage.
- Accepts one operation per valid/ready handshake and runs a radix-2 shift-add (MUL*) or restoring-divide (DIV*/REM*) loop over XLEN cycles.
- Returns a one-cycle result pulse and drives a busy/stall signal to the pipeline hazard logic.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.
- ZERO_BYPASS, 1, when 1 a MUL* with either operand zero skips CALC and completes in DONE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  operation request.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  input  XLEN  rs1 operand.
- req_b  input  XLEN  rs2 operand.
- flush  input  1  abort the in-flight op (branch mispredict/trap).
- busy  output  1  high while state != IDLE; stalls the pipeline.
- resp_valid  output  1  one-cycle result strobe.
- resp_data  output  XLEN  result; holds its last value until the next resp_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; busy=0; resp_valid=0; resp_data=0; all internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accepts when req_valid && req_ready; latches op, operand magnitudes, result-sign flag and the high/low select.
  - Next state is DONE for special cases (below), otherwise CALC with the counter loaded to XLEN-1.
- CALC:
  - One iteration per cycle. MUL: add multiplicand when the multiplier LSB is 1, shift into a 2*XLEN accumulator. DIV: shift remainder left, trial-subtract the divisor, set the quotient bit.
  - Counter decrements; at 0 the next state is DONE.
  - Normal latency is XLEN+1 cycles from the accept edge to the resp_valid cycle (33 for XLEN=32).
- DONE:
  - resp_valid=1 for exactly one cycle and resp_data is registered.
  - Next state is IDLE; req_ready returns the following cycle (no back-to-back accept while in DONE).
- Sign rules:
  - MUL/MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: both unsigned.
  - Operate on magnitudes; negate the 2*XLEN product when the operand signs differ.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- Special cases (1 cycle to DONE, latency 1):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - DIV a=0x80000000, b=0xFFFFFFFF gives 0x80000000; REM gives 0.
  - With ZERO_BYPASS=1, a MUL* with a zero operand gives 0.
- flush:
  - In CALC or DONE: next state is IDLE, resp_valid is suppressed that cycle, resp_data is unchanged.
  - In IDLE: a request in the same cycle is not accepted.
  - flush has priority over completion.
- busy equals !req_ready at all times.
- req_* are sampled only at accept; later changes have no effect.
- Reset asserted mid-operation aborts immediately; no resp_valid is produced.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD): resp_data=0xFFFFFFEB; resp_valid exactly 33 cycles after the accept edge, single cycle; busy high throughout.
- MULH a=0x80000000, b=0x80000000 gives 0x40000000. MULHSU a=-1, b=0xFFFFFFFF gives 0xFFFFFFFF. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF gives 0xFFFFFFFE.
- DIV a=-7, b=2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU a=100, b=7 gives 14; REMU gives 2.
- DIV a=5, b=0 gives 0xFFFFFFFF with 1-cycle latency. REM a=5, b=0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
- Flush 10 cycles into a DIV: no resp_valid; req_ready high next cycle; a following MULHU 3*5 returns 0 correctly.
- Deassert rst_n mid-CALC: outputs go to reset values immediately; after release, a fresh MUL 6*7 returns 42.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/flush/response bundle between the EX stage and muldiv_seq
//   master: drives req_valid/req_op/req_a/req_b/flush; sees req_ready/busy/resp_valid/resp_data
//   slave : the unit itself
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  modport master (output req_valid, req_op, req_a, req_b, flush,
                  input  req_ready, busy, resp_valid, resp_data);
  modport slave  (input  req_valid, req_op, req_a, req_b, flush,
                  output req_ready, busy, resp_valid, resp_data);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide)
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : muldiv_seq_if.slave -- request handshake, flush, busy stall, one-cycle result strobe
module muldiv_seq #(
  parameter int XLEN        = 32,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d, resp_data_q, resp_data_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              accept, is_div, sa, sb, div0, ovf, zbyp;
  logic [XLEN-1:0]   ma, mb, spec, qr, fin;
  logic [XLEN:0]     madd, dsh, ddif;
  logic [2*XLEN-1:0] step, prod;
  assign accept = bus.req_valid && state_q == IDLE && !bus.flush;
  assign is_div = bus.req_op[2];
  assign sa     = bus.req_a[XLEN-1] && (is_div ? !bus.req_op[0] : bus.req_op[1:0] != 2'b11);
  assign sb     = bus.req_b[XLEN-1] && (is_div ? !bus.req_op[0] : !bus.req_op[1]);
  assign ma     = sa ? -bus.req_a : bus.req_a;
  assign mb     = sb ? -bus.req_b : bus.req_b;
  assign div0   = is_div && bus.req_b == '0;
  assign ovf    = is_div && !bus.req_op[0] && bus.req_a == {1'b1, {(XLEN-1){1'b0}}} && bus.req_b == '1;
  assign zbyp   = ZERO_BYPASS && !is_div && (bus.req_a == '0 || bus.req_b == '0);
  assign spec   = div0 ? (bus.req_op[1] ? bus.req_a : '1) : ovf ? (bus.req_op[1] ? '0 : bus.req_a) : '0;
  // Multiply: acc = {partial sum, remaining multiplier}, shifted right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
  assign madd = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign dsh  = acc_q[2*XLEN-1:XLEN-1];
  assign ddif = dsh - {1'b0, opnd_q};
  assign step = op_q[2] ? (ddif[XLEN] ? {dsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {ddif[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                        : {madd, acc_q[XLEN-1:1]};
  assign prod = neg_q ? -step : step;
  assign qr   = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
  assign fin  = op_q[2] ? (neg_q ? -qr : qr) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  // Result strobe is gated by flush combinationally so a flush in DONE wins over completion.
  assign bus.req_ready  = state_q == IDLE;
  assign bus.busy       = state_q != IDLE;
  assign bus.resp_valid = state_q == DONE && !bus.flush;
  assign bus.resp_data  = bus.resp_valid ? res_q : resp_data_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    res_d       = res_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      IDLE: if (accept) begin
        op_d  = bus.req_op;
        neg_d = (is_div && bus.req_op[1]) ? sa : sa ^ sb;
        if (div0 || ovf || zbyp) begin
          res_d   = spec;
          state_d = DONE;
        end else begin
          opnd_d  = is_div ? mb : ma;
          acc_d   = {{XLEN{1'b0}}, is_div ? ma : mb};
          cnt_d   = CW'(XLEN-1);
          state_d = CALC;
        end
      end
      CALC: if (bus.flush) state_d = IDLE;
      else begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d   = fin;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.flush) resp_data_d = res_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      resp_data_q <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table + scoreboard bench for muldiv_seq, with flush and reset corner sequences
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  muldiv_seq_if #(.XLEN(32)) bus();
  muldiv_seq #(.XLEN(32), .ZERO_BYPASS(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (bus.resp_valid === 1'b1) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp actual=resp_valid data=%h required=no response", bus.resp_data);
    end else chk("resp_data", bus.resp_data, sb.pop_front());
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask
  task automatic wait_resp(input int lat_exp, input logic [31:0] exp);
    int lat = 0;
    logic busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.busy) busy_ok = 1'b0;
    end while (!bus.resp_valid && lat < 100);
    chk("latency", lat, lat_exp);
    chk("busy_during_op", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk("resp_single_cycle", {31'd0, bus.resp_valid}, 32'd0);
    chk("ready_after_done", {31'd0, bus.req_ready}, 32'd1);
    chk("resp_hold", bus.resp_data, exp);
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(op, a, b, 1'b1, exp);
    wait_resp(lat, exp);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    vecs.push_back(vec_t'{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back(vec_t'{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back(vec_t'{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back(vec_t'{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back(vec_t'{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back(vec_t'{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back(vec_t'{3'b101, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back(vec_t'{3'b111, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back(vec_t'{3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33});
    vecs.push_back(vec_t'{3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33});
    vecs.push_back(vec_t'{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33});
    vecs.push_back(vec_t'{3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33});
    vecs.push_back(vec_t'{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 33});
    vecs.push_back(vec_t'{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back(vec_t'{3'b110, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back(vec_t'{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back(vec_t'{3'b111, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back(vec_t'{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back(vec_t'{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back(vec_t'{3'b000, 32'd0,        32'd1234,     32'd0,        1});
    vecs.push_back(vec_t'{3'b001, 32'd12345,    32'd0,        32'd0,        1});
    #1;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    issue(3'b101, 32'd100, 32'd7, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_calc_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("flush_calc_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_calc_data", bus.resp_data, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    chk("flush_calc_no_resp", seen, 0);
    run(3'b011, 32'd3, 32'd5, 32'd0, 33);
    issue(3'b100, 32'd5, 32'd0, 1'b0, 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("flush_done_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("flush_done_data", bus.resp_data, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_done_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    chk("flush_done_hold", bus.resp_data, 32'd0);
    bus.flush     = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd9;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_idle_no_accept", {31'd0, bus.req_ready}, 32'd1);
    chk("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'b000, 32'd6, 32'd7, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midrst_resp_data", bus.resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'b000, 32'd6, 32'd7, 32'd42, 33);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
